axi_w_burst_gate: RTL and testbench

Downstream stage of the RAB write-data BRAM buffer. Pops buffered AXI W beats and, per burst, either forwards them to the master port or discards them, according to a per-burst forward/drop decision from the AW translation stage. Decisions are queued in a small FIFO so translation can run ahead of the data. Each discarded burst raises a pulse to the B-response generator, and a saturating counter tracks discarded beats.

---
 rtl/axi_rab_pkg.sv | 15 +
 rtl/axi_w_burst_gate_if.sv | 15 +
 rtl/axi_dec_fifo.sv | 39 +++
 rtl/axi_w_burst_gate.sv | 83 ++++++++
 tb/tb_axi_w_burst_gate.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/axi_rab_pkg.sv
// axi_rab_pkg: shared types and constants for the RAB write-data gate
//   gate_state_t  - burst gate FSM states
//   w_beat_t      - one W beat (data, strb, user, last) at the default widths
package axi_rab_pkg;
  localparam int W_DATA_WIDTH = 64;
  localparam int W_USER_WIDTH = 6;
  localparam int DROP_CNT_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, FWD, DROP} gate_state_t;
  typedef struct packed {
    logic [W_DATA_WIDTH-1:0]   data;
    logic [W_DATA_WIDTH/8-1:0] strb;
    logic [W_USER_WIDTH-1:0]   user;
    logic                      last;
  } w_beat_t;
endpackage

// File: rtl/axi_w_burst_gate_if.sv
// axi_w_burst_gate_if: AXI W channel bundle
//   master drives data/strb/user/last/valid and samples ready; slave the reverse
interface axi_w_burst_gate_if #(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 6
);
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;
  logic [USER_WIDTH-1:0]   user;
  logic                    last;
  logic                    valid;
  logic                    ready;
  modport master (output data, strb, user, last, valid, input ready);
  modport slave (input data, strb, user, last, valid, output ready);
endinterface

// File: rtl/axi_dec_fifo.sv
// axi_dec_fifo: DEPTH x 1-bit register FIFO of forward/drop decisions
//   push/din write when not full, pop advances when not empty,
//   dout is the current head, full/empty from the occupancy count
module axi_dec_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/axi_w_burst_gate.sv
// axi_w_burst_gate: per-burst forward/drop gate for buffered AXI W beats
//   s_w        - beats popped from the write-data buffer
//   m_w        - forwarded beats towards the master port
//   dec_*      - forward(0)/drop(1) decisions, queued in a small FIFO
//   drop_done  - one-cycle pulse after each discarded burst
//   len_err    - one-cycle pulse when a burst reaches MAX_BEATS without last
//   drop_beats - saturating discarded-beat count, cleared by drop_clr
module axi_w_burst_gate
  import axi_rab_pkg::*;
#(
  parameter int DATA_WIDTH = W_DATA_WIDTH,
  parameter int USER_WIDTH = W_USER_WIDTH,
  parameter int DEC_DEPTH  = 4,
  parameter int MAX_BEATS  = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  axi_w_burst_gate_if.slave         s_w,
  axi_w_burst_gate_if.master        m_w,
  input  logic                      dec_valid,
  input  logic                      dec_drop,
  output logic                      dec_ready,
  output logic                      drop_done,
  output logic                      len_err,
  output logic [DROP_CNT_WIDTH-1:0] drop_beats,
  input  logic                      drop_clr
);
  localparam int CW = $clog2(MAX_BEATS) + 1;
  gate_state_t state, state_nx;
  logic [CW-1:0] beat_cnt;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [DATA_WIDTH/8-1:0] fwd_strb;
  logic [USER_WIDTH-1:0] fwd_user;
  logic fifo_full, fifo_empty, fifo_head, pop, acc, at_max, burst_end;
  axi_dec_fifo #(.DEPTH(DEC_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(dec_valid),
    .pop(pop),
    .din(dec_drop),
    .dout(fifo_head),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  assign dec_ready = !fifo_full;
  assign pop = state == IDLE && !fifo_empty;
  // the beat being accepted now is the MAX_BEATS-th of the burst
  assign at_max = beat_cnt == CW'(MAX_BEATS - 1);
  assign acc = s_w.valid && s_w.ready;
  assign burst_end = acc && (s_w.last || at_max);
  assign s_w.ready = state == DROP || (state == FWD && m_w.ready);
  assign fwd_data = s_w.data;
  assign fwd_strb = s_w.strb;
  assign fwd_user = s_w.user;
  assign m_w.data = fwd_data;
  assign m_w.strb = fwd_strb;
  assign m_w.user = fwd_user;
  assign m_w.valid = state == FWD && s_w.valid;
  assign m_w.last = state == FWD && (s_w.last || at_max);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = pop ? (fifo_head ? DROP : FWD) : IDLE;
    else if (burst_end) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      drop_done <= 1'b0;
      len_err <= 1'b0;
      drop_beats <= '0;
    end else begin
      beat_cnt <= (state == IDLE || burst_end) ? '0 : beat_cnt + CW'(acc);
      drop_done <= burst_end && state == DROP;
      len_err <= burst_end && at_max && !s_w.last;
      if (drop_clr) drop_beats <= '0;
      else if (acc && state == DROP && !(&drop_beats)) drop_beats <= drop_beats + 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_w_burst_gate.sv
// tb_axi_w_burst_gate: randomized self-checking bench against a beat-level reference model
module tb_axi_w_burst_gate;
  import axi_rab_pkg::*;
  typedef struct {
    w_beat_t b;
    bit      drop;
    bit      exp_last;
  } beat_t;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dec_valid = 1'b0, dec_drop = 1'b0, dec_ready, drop_done, len_err, drop_clr = 1'b0;
  logic [31:0] drop_beats;
  axi_w_burst_gate_if s_w ();
  axi_w_burst_gate_if m_w ();
  axi_w_burst_gate dut (
    .clk(clk),
    .rst(rst),
    .s_w(s_w),
    .m_w(m_w),
    .dec_valid(dec_valid),
    .dec_drop(dec_drop),
    .dec_ready(dec_ready),
    .drop_done(drop_done),
    .len_err(len_err),
    .drop_beats(drop_beats),
    .drop_clr(drop_clr)
  );
  always #5 clk = ~clk;
  bit dec_q[$];
  beat_t src_q[$];
  longint exp_drop = 0;
  int exp_dd = 0, exp_le = 0, obs_dd = 0, obs_le = 0;
  int n_chk = 0, n_fail = 0;
  int lat;
  always @(negedge clk) if (!rst) begin
    obs_dd += int'(drop_done);
    obs_le += int'(len_err);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic add_burst(input bit drop, input int len, input bit no_last, input int base);
    dec_q.push_back(drop);
    for (int i = 0; i < len; i++) begin
      beat_t x;
      x.b.data = base != 0 ? 64'(base + i) : {$urandom, $urandom};
      x.b.strb = 8'($urandom);
      x.b.user = 6'($urandom);
      x.b.last = !no_last && i == len - 1;
      x.exp_last = i == len - 1;
      x.drop = drop;
      src_q.push_back(x);
    end
  endtask
  // mode 0: always ready, 1: random valid/ready, 2: m_w.ready pattern 1,0,0,1
  task automatic run(input int mode, input bit beats_en, input int budget, input int stop_after,
                     input bit clr_mode, output int latency);
    int cyc = 0, taken = 0, t_dec = -1, t_beat = -1;
    bit held = 0, prev_end = 0;
    logic [3:0] pat = 4'b1001;
    while ((dec_q.size() > 0 || (beats_en && src_q.size() > 0)) && cyc < budget && taken != stop_after) begin
      @(negedge clk);
      drop_clr = 1'b0;
      dec_valid = dec_q.size() > 0 && (mode != 1 || $urandom_range(0, 1) == 1);
      dec_drop = dec_q.size() > 0 ? dec_q[0] : 1'b0;
      if (!held) begin
        s_w.valid = beats_en && src_q.size() > 0 && (mode != 1 || $urandom_range(0, 3) != 0);
        if (src_q.size() > 0) begin
          s_w.data = src_q[0].b.data;
          s_w.strb = src_q[0].b.strb;
          s_w.user = src_q[0].b.user;
          s_w.last = src_q[0].b.last;
        end
      end
      m_w.ready = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(0, 2) != 0) : pat[cyc % 4];
      #2;
      if (prev_end) chk("bubble", s_w.ready, 0);
      if (m_w.valid) chk("mirror", s_w.ready, m_w.ready);
      prev_end = 0;
      if (dec_valid && dec_ready) begin
        void'(dec_q.pop_front());
        if (t_dec < 0) t_dec = cyc;
      end
      if (s_w.valid && s_w.ready) begin
        beat_t x = src_q.pop_front();
        chk("route", m_w.valid, !x.drop);
        if (!x.drop) begin
          chk("data", m_w.data, x.b.data);
          chk("strb", m_w.strb, x.b.strb);
          chk("user", m_w.user, x.b.user);
          chk("last", m_w.last, x.exp_last);
        end else begin
          exp_drop = exp_drop >= CNT_MAX ? CNT_MAX : exp_drop + 1;
          if (x.exp_last) exp_dd++;
        end
        if (clr_mode) begin
          drop_clr = 1'b1;
          exp_drop = 0;
        end
        if (x.exp_last && !x.b.last) exp_le++;
        prev_end = x.exp_last;
        if (t_beat < 0) t_beat = cyc;
        taken++;
      end
      held = s_w.valid && !s_w.ready;
      cyc++;
    end
    if (stop_after < 0) begin
      chk("timeout", 64'(dec_q.size() + (beats_en ? src_q.size() : 0)), 0);
      @(negedge clk);
      drop_clr = 1'b0;
      dec_valid = 1'b0;
      s_w.valid = 1'b0;
      #2;
      if (prev_end) chk("bubble", s_w.ready, 0);
      repeat (2) @(negedge clk);
      #1;
    end
    latency = t_beat - t_dec;
  endtask
  task automatic chk_totals(input string tag);
    chk({tag, "_drop_beats"}, drop_beats, exp_drop);
    chk({tag, "_drop_done"}, obs_dd, exp_dd);
    chk({tag, "_len_err"}, obs_le, exp_le);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dec_ready"}, dec_ready, 1);
    chk({tag, "_s_ready"}, s_w.ready, 0);
    chk({tag, "_m_valid"}, m_w.valid, 0);
    chk({tag, "_m_last"}, m_w.last, 0);
    chk({tag, "_drop_done"}, drop_done, 0);
    chk({tag, "_len_err"}, len_err, 0);
    chk({tag, "_drop_beats"}, drop_beats, 0);
  endtask
  initial begin
    s_w.valid = 1'b0;
    s_w.data = '0;
    s_w.strb = '0;
    s_w.user = '0;
    s_w.last = 1'b0;
    m_w.ready = 1'b1;
    repeat (2) @(negedge clk);
    s_w.valid = 1'b1;
    s_w.last = 1'b1;
    #1;
    chk_reset_vals("reset");
    s_w.valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    add_burst(0, 4, 0, 1);
    run(0, 1, 100, -1, 0, lat);
    chk("fwd_latency", lat, 2);
    chk_totals("fwd4");
    add_burst(1, 3, 0, 0);
    run(0, 1, 100, -1, 0, lat);
    chk_totals("drop3");
    add_burst(0, 4, 0, 16);
    run(2, 1, 100, -1, 0, lat);
    chk_totals("backpressure");
    for (int i = 0; i < 5; i++) add_burst(i % 2 == 1, 2, 0, 0);
    run(0, 0, 100, -1, 0, lat);
    chk("fifo_full_ready", dec_ready, 0);
    run(0, 1, 200, -1, 0, lat);
    chk_totals("fifo_fill");
    add_burst(0, 256, 1, 256);
    add_burst(0, 2, 0, 0);
    run(0, 1, 1000, -1, 0, lat);
    chk_totals("len_err");
    for (int i = 0; i < 30; i++) add_burst($urandom_range(0, 1) == 1, $urandom_range(1, 8), 0, 0);
    run(1, 1, 5000, -1, 0, lat);
    chk_totals("random");
    add_burst(1, 1, 0, 0);
    run(0, 1, 100, -1, 1, lat);
    chk_totals("clr");
    @(negedge clk);
    force dut.drop_beats = 32'hFFFF_FFFF;
    #1;
    release dut.drop_beats;
    exp_drop = CNT_MAX;
    add_burst(1, 1, 0, 0);
    run(0, 1, 100, -1, 0, lat);
    chk_totals("saturate");
    add_burst(1, 4, 0, 0);
    run(0, 1, 100, 2, 0, lat);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    dec_q.delete();
    src_q.delete();
    exp_drop = 0;
    @(negedge clk);
    rst = 1'b0;
    dec_valid = 1'b0;
    s_w.valid = 1'b1;
    s_w.last = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #2;
      chk("held_after_rst", s_w.ready, 0);
    end
    s_w.valid = 1'b0;
    chk_totals("after_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
